// File: rtl/mulpp_pkg.sv
// Shared constants for the pipelined shift-add multiply-accumulate.
// Width defaults and stage count used by mulpp and mulstage.
package mulpp_pkg;

  localparam int MUL_W  = 8;
  localparam int MUL_RW = 2 * MUL_W;
  localparam int STAGES = MUL_W;

endpackage

// File: rtl/mulstage.sv
// One combinational shift-add step: adds quo<<K when multiplier bit K is set.
// The adder is 2W wide; the result never exceeds 2^2W - 2^W, so no carry is lost.
module mulstage
  import mulpp_pkg::*;
#(
  parameter int W = MUL_W,
  parameter int K = 0
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   quo,
  input  logic [W-1:0]   den,
  output logic [2*W-1:0] acc_nxt
);

  logic [2*W-1:0] pp;
  logic           unused_den;

  assign pp = den[K]
            ? ({{W{1'b0}}, quo} << K)
            : '0;

  assign acc_nxt = acc + pp;

  // Only bit K matters here; the rest rides along for later stages.
  assign unused_den = ^den;

endmodule

// File: rtl/mulpp.sv
// Pipelined W x W multiply with addend: num = quo*den + rem.
// One shift-add stage per multiplier bit, a register rank after each.
module mulpp
  import mulpp_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [W-1:0]   quo,
  input  logic [W-1:0]   den,
  input  logic [W-1:0]   rem,
  output logic           out_valid,
  output logic [2*W-1:0] num,
  output logic           ovf,
  output logic           rem_err
);

  localparam int RW = 2 * W;

  logic [RW-1:0] acc_in  [W];
  logic [RW-1:0] acc_out [W];
  logic [RW-1:0] acc_q   [W];
  logic [W-1:0]  quo_in  [W];
  logic [W-1:0]  den_in  [W];

  // The last rank only needs the sum; operands stop at rank W-2.
  logic [W-1:0]  quo_q   [W-1];
  logic [W-1:0]  den_q   [W-1];

  logic [W-1:0]  valid_q;
  logic [W-1:0]  err_q;
  logic          err0;

  assign err0 = (rem >= den);

  for (genvar k = 0; k < W; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign acc_in[k] = {{W{1'b0}}, rem};
      assign quo_in[k] = quo;
      assign den_in[k] = den;
    end else begin : g_tail
      assign acc_in[k] = acc_q[k-1];
      assign quo_in[k] = quo_q[k-1];
      assign den_in[k] = den_q[k-1];
    end

    mulstage #(
      .W (W),
      .K (k)
    ) u_stage (
      .acc     (acc_in[k]),
      .quo     (quo_in[k]),
      .den     (den_in[k]),
      .acc_nxt (acc_out[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < W; k++) begin
        acc_q[k] <= '0;
      end
      for (int k = 0; k < W-1; k++) begin
        quo_q[k] <= '0;
        den_q[k] <= '0;
      end
    end else if (en) begin
      valid_q <= {valid_q[W-2:0], in_valid};
      err_q   <= {err_q[W-2:0], err0};
      for (int k = 0; k < W; k++) begin
        acc_q[k] <= acc_out[k];
      end
      for (int k = 0; k < W-1; k++) begin
        quo_q[k] <= quo_in[k];
        den_q[k] <= den_in[k];
      end
    end
  end

  assign out_valid = valid_q[W-1];
  assign num       = acc_q[W-1];
  assign ovf       = |num[RW-1:W];
  assign rem_err   = err_q[W-1];

endmodule

// File: tb/tb_mulpp.sv
// Self-checking bench for mulpp: directed cases plus random traffic,
// scored against an arithmetic model keyed on the count of enabled edges.
module tb_mulpp;
  import mulpp_pkg::*;

  localparam int W = MUL_W;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           in_valid;
  logic [W-1:0]   quo;
  logic [W-1:0]   den;
  logic [W-1:0]   rem;
  logic           out_valid;
  logic [2*W-1:0] num;
  logic           ovf;
  logic           rem_err;

  always #5 clk = ~clk;

  mulpp #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .quo       (quo),
    .den       (den),
    .rem       (rem),
    .out_valid (out_valid),
    .num       (num),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  // An op accepted on enabled edge e is due at the outputs once
  // the enabled-edge count reaches e + W - 1.
  typedef struct {
    int due;
    int num;
    bit ovf;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   en_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   first;
  int   seen;
  int   idx;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare();
    bit   ev;
    exp_t e;
    while (sb.size() > 0 && sb[0].due < en_cnt)
      void'(sb.pop_front());
    ev = (sb.size() > 0) && (sb[0].due == en_cnt);
    check("out_valid", 32'(out_valid), 32'(ev));
    if (ev && out_valid) begin
      e = sb[0];
      check("num", 32'(num), 32'(e.num));
      check("ovf", 32'(ovf), 32'(e.ovf));
      check("rem_err", 32'(rem_err), 32'(e.err));
    end
  endtask

  task automatic clr_obs();
    first = -1;
    seen  = 0;
    idx   = 0;
  endtask

  task automatic cyc(input bit e, input bit v,
                     input int q, input int d, input int r);
    exp_t x;
    int   p;
    en       = e;
    in_valid = v;
    quo      = W'(q);
    den      = W'(d);
    rem      = W'(r);
    @(posedge clk);
    if (e) begin
      en_cnt++;
      if (v) begin
        p     = q * d + r;
        x.due = en_cnt + W - 1;
        x.num = p;
        x.ovf = (p > (1 << W) - 1);
        x.err = (r >= d);
        sb.push_back(x);
      end
    end
    @(negedge clk);
    compare();
    if (out_valid) begin
      if (first < 0) first = idx;
      seen++;
    end
    idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    quo      = '0;
    den      = '0;
    rem      = '0;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_num", 32'(num), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_err", 32'(rem_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // single op: 13*7+5 = 96
    clr_obs();
    cyc(1'b1, 1'b1, 13, 7, 5);
    idle(11);
    check("basic_lat", 32'(first), 32'd7);
    check("basic_cnt", 32'(seen), 32'd1);

    // max operands: 255*255+254 = 65279
    clr_obs();
    cyc(1'b1, 1'b1, 255, 255, 254);
    idle(9);
    check("max_cnt", 32'(seen), 32'd1);

    // zero divisor: num = rem, rem_err set
    clr_obs();
    cyc(1'b1, 1'b1, 200, 0, 9);
    idle(9);
    check("zero_cnt", 32'(seen), 32'd1);

    // back-to-back stream
    clr_obs();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, i, i + 1, i);
    idle(10);
    check("b2b_first", 32'(first), 32'd7);
    check("b2b_cnt", 32'(seen), 32'd8);

    // 5-cycle stall mid-pipe; in_valid asserted while stalled is ignored
    clr_obs();
    for (int i = 0; i < 20; i++) begin
      bit s;
      s = (i >= 3) && (i < 8);
      cyc(!s, (i == 0) || s, 10, 10, 3);
    end
    check("stall_lat", 32'(first), 32'd12);
    check("stall_cnt", 32'(seen), 32'd1);

    // async reset with ops in flight and a result on the outputs
    clr_obs();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 200 - i, 200, i + 1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_num", 32'(num), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_err", 32'(rem_err), 32'd0);
    sb.delete();
    en       = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_num", 32'(num), 32'd0);
    reset = 1'b0;
    clr_obs();
    idle(10);
    check("rst_stale", 32'(seen), 32'd0);
    clr_obs();
    cyc(1'b1, 1'b1, 3, 4, 2);
    idle(9);
    check("rst_fresh_lat", 32'(first), 32'd7);
    check("rst_fresh_cnt", 32'(seen), 32'd1);

    // random traffic with random stalls
    for (int n = 0; n < 400; n++) begin
      int sel;
      int q;
      int d;
      int r;
      sel = $urandom_range(0, 7);
      q   = $urandom_range(0, 255);
      d   = $urandom_range(0, 255);
      r   = $urandom_range(0, 255);
      if (sel == 0) begin
        q = 255;
        d = 255;
      end else if (sel == 1) begin
        d = 0;
      end
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, q, d, r);
    end
    idle(12);
    check("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
